// File: rtl/lfsr_encode_seq_if.sv
// Job request, memory port and shared-ALU signals between the LFSR encode sequencer and its surroundings.
// The sequencer takes the master view; the core-side mux and memory/ALU use the slave view.
interface lfsr_encode_seq_if;
  logic       Start;
  logic [6:0] Tap;
  logic [6:0] Seed;
  logic [7:0] SrcBase;
  logic [7:0] DstBase;
  logic [6:0] Len;
  logic [7:0] MemAddr;
  logic       MemWrEn;
  logic [7:0] MemWrData;
  logic [7:0] MemRdData;
  logic [7:0] AluA;
  logic [7:0] AluB;
  logic [3:0] AluOp;
  logic [2:0] AluFlags;
  logic [7:0] AluOut;
  logic       Busy;
  logic       Done;
  logic [6:0] FinalState;

  modport master (
    input  Start, Tap, Seed, SrcBase, DstBase, Len, MemRdData, AluOut,
    output MemAddr, MemWrEn, MemWrData, AluA, AluB, AluOp, AluFlags, Busy, Done, FinalState
  );

  modport slave (
    output Start, Tap, Seed, SrcBase, DstBase, Len, MemRdData, AluOut,
    input  MemAddr, MemWrEn, MemWrData, AluA, AluB, AluOp, AluFlags, Busy, Done, FinalState
  );
endinterface

// File: rtl/lfsr_encode_seq.sv
// Multi-cycle LFSR encryption sequencer: per byte READ -> XOR -> PAR -> WRST, borrowing the
// shared ALU and data memory port while Busy.
module lfsr_encode_seq #(
  parameter logic [3:0] OP_XOR    = 4'h0,
  parameter logic [3:0] OP_PARITY = 4'h0,
  parameter logic [3:0] OP_LFSR   = 4'h0,
  parameter int         MAX_LEN   = 64
) (
  input  logic               Clk,
  input  logic               Reset,
  lfsr_encode_seq_if.master  bus
);

  localparam logic [6:0] LP_MAX_LEN = 7'(MAX_LEN);

  typedef enum logic [2:0] {
    ST_IDLE, ST_READ, ST_XOR, ST_PAR, ST_WRST, ST_DONE
  } state_t;

  state_t     r_state, w_next;
  logic [6:0] r_tap, r_s, r_len, r_i, r_final;
  logic [7:0] r_src, r_dst, r_d, r_x, r_p;
  logic [6:0] w_len_clamp, w_i_inc;
  logic       w_last;

  assign w_len_clamp = (bus.Len > LP_MAX_LEN) ? LP_MAX_LEN : bus.Len;
  assign w_i_inc     = r_i + 7'd1;
  assign w_last      = (w_i_inc == r_len);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (bus.Start) w_next = (w_len_clamp == 7'd0) ? ST_DONE : ST_READ;
      ST_READ: w_next = ST_XOR;
      ST_XOR:  w_next = ST_PAR;
      ST_PAR:  w_next = ST_WRST;
      ST_WRST: w_next = w_last ? ST_DONE : ST_READ;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Job registers and per-byte intermediates; FinalState loads on the edge entering DONE.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_tap   <= '0;
      r_s     <= '0;
      r_len   <= '0;
      r_i     <= '0;
      r_src   <= '0;
      r_dst   <= '0;
      r_d     <= '0;
      r_x     <= '0;
      r_p     <= '0;
      r_final <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (bus.Start) begin
          r_tap <= bus.Tap;
          r_s   <= bus.Seed;
          r_src <= bus.SrcBase;
          r_dst <= bus.DstBase;
          r_len <= w_len_clamp;
          r_i   <= '0;
          if (w_len_clamp == 7'd0) r_final <= bus.Seed;
        end
        ST_READ: r_d <= bus.MemRdData;
        ST_XOR:  r_x <= bus.AluOut;
        ST_PAR:  r_p <= bus.AluOut;
        ST_WRST: begin
          r_s <= bus.AluOut[6:0];
          r_i <= w_i_inc;
          if (w_last) r_final <= bus.AluOut[6:0];
        end
        default: ;
      endcase
    end
  end

  // Outputs decode from state and registers only, so Start never reaches the memory/ALU pins.
  always_comb begin
    bus.MemAddr   = '0;
    bus.MemWrEn   = 1'b0;
    bus.MemWrData = '0;
    bus.AluA      = '0;
    bus.AluB      = '0;
    bus.AluOp     = '0;
    case (r_state)
      ST_READ: bus.MemAddr = r_src + {1'b0, r_i};
      ST_XOR: begin
        bus.AluA  = r_d;
        bus.AluB  = {1'b0, r_s};
        bus.AluOp = OP_XOR;
      end
      ST_PAR: begin
        bus.AluB  = r_x;
        bus.AluOp = OP_PARITY;
      end
      ST_WRST: begin
        bus.MemAddr   = r_dst + {1'b0, r_i};
        bus.MemWrEn   = 1'b1;
        bus.MemWrData = r_p;
        bus.AluA      = {1'b0, r_tap};
        bus.AluB      = {1'b0, r_s};
        bus.AluOp     = OP_LFSR;
      end
      default: ;
    endcase
  end

  assign bus.AluFlags   = 3'b000;
  assign bus.Busy       = (r_state != ST_IDLE);
  assign bus.Done       = (r_state == ST_DONE);
  assign bus.FinalState = r_final;

endmodule

// File: tb/tb_lfsr_encode_seq.sv
// Directed bench for lfsr_encode_seq with a behavioural memory/ALU and a write scoreboard.
module tb_lfsr_encode_seq;

  localparam logic [3:0] K_XOR = 4'h1, K_PAR = 4'h2, K_LFSR = 4'h3;

  typedef struct { logic [7:0] a; logic [7:0] d; } wr_t;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [7:0] mem [0:255];
  wr_t        sb_q[$];
  int         wr_cyc[$];
  logic [7:0] gold [0:63];
  int         checks = 0, errors = 0;
  int         cyc = 0, t0 = 0, wr_count = 0, done_cnt = 0, last_done_cyc = 0;

  lfsr_encode_seq_if bus();

  lfsr_encode_seq #(.OP_XOR(K_XOR), .OP_PARITY(K_PAR), .OP_LFSR(K_LFSR), .MAX_LEN(64))
    dut (.Clk(Clk), .Reset(Reset), .bus(bus));

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  assign bus.MemRdData = mem[bus.MemAddr];

  always_comb begin
    case (bus.AluOp)
      K_XOR:   bus.AluOut = bus.AluA ^ bus.AluB;
      K_PAR:   bus.AluOut = {^bus.AluB[6:0], bus.AluB[6:0]};
      K_LFSR:  bus.AluOut = {1'b0, bus.AluB[5:0], ^(bus.AluA[6:0] & bus.AluB[6:0])};
      default: bus.AluOut = 8'h00;
    endcase
  end

  always @(posedge Clk) if (bus.MemWrEn) mem[bus.MemAddr] <= bus.MemWrData;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write scoreboard and Done/write-cycle monitor, sampled on the falling edge.
  always @(negedge Clk) begin
    wr_t e;
    if (bus.Done) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
    if (bus.MemWrEn) begin
      wr_count++;
      wr_cyc.push_back(cyc);
      check("sb_expected_write", sb_q.size() != 0, 1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("sb_addr", bus.MemAddr, e.a);
        check("sb_data", bus.MemWrData, e.d);
      end
    end
  end

  task automatic push_job(input logic [6:0] tap, input logic [6:0] seed, input logic [7:0] src,
                          input logic [7:0] dst, input logic [6:0] len, output logic [6:0] fs);
    logic [6:0] s, l;
    logic [7:0] b, x, p;
    wr_t e;
    s = seed;
    l = (len > 7'd64) ? 7'd64 : len;
    for (int i = 0; i < int'(l); i++) begin
      b = mem[8'(src + 8'(i))];
      x = b ^ {1'b0, s};
      p = {^x[6:0], x[6:0]};
      e.a = 8'(dst + 8'(i));
      e.d = p;
      sb_q.push_back(e);
      gold[i] = p;
      s = {s[5:0], ^(s & tap)};
    end
    fs = s;
  endtask

  task automatic start_job(input logic [6:0] tap, input logic [6:0] seed, input logic [7:0] src,
                           input logic [7:0] dst, input logic [6:0] len);
    @(negedge Clk);
    bus.Tap = tap; bus.Seed = seed; bus.SrcBase = src; bus.DstBase = dst; bus.Len = len;
    bus.Start = 1'b1;
    @(posedge Clk);
    #1;
    t0 = cyc;
    bus.Start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n0;
    n0 = done_cnt;
    for (int k = 0; k < budget && done_cnt == n0; k++) @(negedge Clk);
    check(tag, done_cnt != n0, 1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, bus.Busy, 0);
    check({tag, "_done"}, bus.Done, 0);
    check({tag, "_wren"}, bus.MemWrEn, 0);
    check({tag, "_addr"}, bus.MemAddr, 0);
    check({tag, "_wdata"}, bus.MemWrData, 0);
    check({tag, "_alua"}, bus.AluA, 0);
    check({tag, "_alub"}, bus.AluB, 0);
    check({tag, "_aluop"}, bus.AluOp, 0);
    check({tag, "_flags"}, bus.AluFlags, 0);
    check({tag, "_final"}, bus.FinalState, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] fs;
    int d0, w0;
    Reset = 1'b0;
    bus.Start = 1'b0; bus.Tap = '0; bus.Seed = '0; bus.SrcBase = '0; bus.DstBase = '0; bus.Len = '0;
    for (int k = 0; k < 256; k++) mem[k] = 8'(k * 37 + 11);
    repeat (3) @(negedge Clk);
    check_zero("reset");
    @(negedge Clk) Reset = 1'b1;

    // Basic encode
    mem[8'h40] = 8'h41; mem[8'h41] = 8'h42;
    push_job(7'h60, 7'h01, 8'h40, 8'h80, 7'd2, fs);
    d0 = done_cnt; wr_cyc.delete();
    start_job(7'h60, 7'h01, 8'h40, 8'h80, 7'd2);
    check("basic_busy_c1", bus.Busy, 1);
    wait_done("basic_done_seen", 40);
    check("basic_done_cyc", last_done_cyc - t0 + 1, 9);
    check("basic_final", bus.FinalState, 7'h04);
    repeat (3) @(negedge Clk);
    check("basic_done_once", done_cnt - d0, 1);
    check("basic_mem80", mem[8'h80], 8'hC0);
    check("basic_mem81", mem[8'h81], 8'hC0);
    check("basic_nwr", wr_cyc.size(), 2);
    check("basic_wr0_cyc", wr_cyc[0] - t0 + 1, 4);
    check("basic_wr1_cyc", wr_cyc[1] - t0 + 1, 8);
    check("basic_idle", bus.Busy, 0);

    // Empty job
    d0 = done_cnt; w0 = wr_count;
    start_job(7'h33, 7'h55, 8'h00, 8'h00, 7'd0);
    wait_done("empty_done_seen", 10);
    check("empty_done_cyc", last_done_cyc - t0 + 1, 1);
    check("empty_final", bus.FinalState, 7'h55);
    repeat (3) @(negedge Clk);
    check("empty_nwr", wr_count - w0, 0);

    // Busy lockout
    push_job(7'h41, 7'h13, 8'h50, 8'h90, 7'd2, fs);
    d0 = done_cnt; w0 = wr_count;
    start_job(7'h41, 7'h13, 8'h50, 8'h90, 7'd2);
    repeat (3) @(negedge Clk);
    bus.Seed = 7'h7E; bus.Start = 1'b1;
    @(negedge Clk) bus.Start = 1'b0;
    wait_done("lock_done_seen", 40);
    check("lock_final", bus.FinalState, fs);
    repeat (15) @(negedge Clk);
    check("lock_done_once", done_cnt - d0, 1);
    check("lock_nwr", wr_count - w0, 2);
    check("lock_idle", bus.Busy, 0);

    // Address wrap
    mem[8'hFF] = 8'h3C; mem[8'h00] = 8'hA5;
    push_job(7'h5A, 7'h2B, 8'hFF, 8'hFE, 7'd2, fs);
    w0 = wr_count;
    start_job(7'h5A, 7'h2B, 8'hFF, 8'hFE, 7'd2);
    wait_done("wrap_done_seen", 40);
    check("wrap_done_cyc", last_done_cyc - t0 + 1, 9);
    check("wrap_final", bus.FinalState, fs);
    check("wrap_nwr", wr_count - w0, 2);

    // Length clamp
    push_job(7'h71, 7'h6D, 8'h00, 8'h80, 7'd100, fs);
    w0 = wr_count;
    start_job(7'h71, 7'h6D, 8'h00, 8'h80, 7'd100);
    wait_done("clamp_done_seen", 400);
    check("clamp_done_cyc", last_done_cyc - t0 + 1, 257);
    check("clamp_final", bus.FinalState, fs);
    check("clamp_nwr", wr_count - w0, 64);

    // Async reset during PAR of byte 1
    for (int k = 0; k < 4; k++) mem[8'hA0 + k] = 8'hEE;
    push_job(7'h2D, 7'h4C, 8'h20, 8'hA0, 7'd1, fs);
    w0 = wr_count;
    start_job(7'h2D, 7'h4C, 8'h20, 8'hA0, 7'd4);
    repeat (7) @(negedge Clk);
    #2 Reset = 1'b0;
    #1 check_zero("arst");
    repeat (3) @(negedge Clk);
    check("arst_nwr", wr_count - w0, 1);
    check("arst_mem_a1", mem[8'hA1], 8'hEE);
    Reset = 1'b1;
    push_job(7'h2D, 7'h4C, 8'h20, 8'hA0, 7'd4, fs);
    start_job(7'h2D, 7'h4C, 8'h20, 8'hA0, 7'd4);
    wait_done("restart_done_seen", 40);
    check("restart_done_cyc", last_done_cyc - t0 + 1, 17);
    check("restart_final", bus.FinalState, fs);

    // In-place encode
    mem[8'h10] = 8'h11; mem[8'h11] = 8'h22; mem[8'h12] = 8'h33;
    push_job(7'h48, 7'h39, 8'h10, 8'h10, 7'd3, fs);
    start_job(7'h48, 7'h39, 8'h10, 8'h10, 7'd3);
    wait_done("inplace_done_seen", 40);
    check("inplace_final", bus.FinalState, fs);
    repeat (2) @(negedge Clk);
    for (int k = 0; k < 3; k++) check("inplace_mem", mem[8'h10 + k], gold[k]);

    check("sb_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
